// File: rtl/sobel_window_gen_pkg.sv
// Shared types for the Sobel 3x3 window generator.
package sobel_pkg;

  localparam int SOBEL_COORD_W = 16;

  typedef logic signed [7:0]       pixel_t;
  typedef logic [SOBEL_COORD_W-1:0] coord_t;

  // Six non-centre-column taps of one 3x3 window, named pRC.
  typedef struct packed {
    pixel_t p00;
    pixel_t p02;
    pixel_t p10;
    pixel_t p12;
    pixel_t p20;
    pixel_t p22;
  } sobel_win_t;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out handshake bundle for sobel_window_gen.
// Optional SOBEL_WIN_SOF_EN adds the sof_i start-of-frame qualifier.
interface sobel_window_gen_if;
  import sobel_pkg::*;

  logic   pix_valid_i;
  logic   pix_ready_o;
  pixel_t pix_data_i;
`ifdef SOBEL_WIN_SOF_EN
  logic   sof_i;
`endif
  logic   win_valid_o;
  logic   win_ready_i;
  pixel_t p00_o, p02_o, p10_o, p12_o, p20_o, p22_o;
  coord_t win_row_o;
  coord_t win_col_o;
  logic   win_last_o;

  // Window generator side.
  modport slave (
`ifdef SOBEL_WIN_SOF_EN
    input  sof_i,
`endif
    input  pix_valid_i, pix_data_i, win_ready_i,
    output pix_ready_o, win_valid_o, p00_o, p02_o, p10_o, p12_o, p20_o, p22_o,
    output win_row_o, win_col_o, win_last_o
  );

  // Pixel source / window sink side.
  modport master (
`ifdef SOBEL_WIN_SOF_EN
    output sof_i,
`endif
    output pix_valid_i, pix_data_i, win_ready_i,
    input  pix_ready_o, win_valid_o, p00_o, p02_o, p10_o, p12_o, p20_o, p22_o,
    input  win_row_o, win_col_o, win_last_o
  );

endinterface

// File: rtl/sobel_window_gen_line_buf.sv
// One image row of pixels in flops. Read is combinational at idx_i and
// returns the old contents when a write hits the same index (read-before-write).
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  pixel_t        wdata_i,
  output pixel_t        rdata_o
);

  pixel_t mem_q [DEPTH];

  assign rdata_o = mem_q[idx_i];

  // Contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding the Sobel detector.
// Buffers two previous rows, emits one registered window per interior pixel.
// Optional macro SOBEL_WIN_SOF_EN: sof_i forces the accepted pixel to (0,0).
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  sobel_window_gen_if.slave bus
);

  localparam int     AW      = $clog2(IMG_WIDTH);
  localparam coord_t COL_MAX = coord_t'(IMG_WIDTH - 1);
  localparam coord_t ROW_MAX = coord_t'(IMG_HEIGHT - 1);

  coord_t col_q, col_d, row_q, row_d;
  coord_t cur_col, cur_row;
  logic   accept, sof, interior;
  pixel_t rd0, rd1;              // img[r-2][c], img[r-1][c]
  pixel_t [2:0] c1_q, c2_q;      // columns c-1 and c-2; index 0 = row r-2
  sobel_win_t win_q, win_d;
  coord_t wrow_q, wrow_d, wcol_q, wcol_d;
  logic   vld_q, vld_d, last_q, last_d;

  // Ready depends only on the output register, never on pix_valid_i.
  assign bus.pix_ready_o = !vld_q || bus.win_ready_i;
  assign accept          = bus.pix_valid_i && bus.pix_ready_o;

`ifdef SOBEL_WIN_SOF_EN
  assign sof = bus.sof_i;
`else
  assign sof = 1'b0;
`endif

  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  assign cur_col  = sof ? '0 : col_q;
  assign cur_row  = sof ? '0 : row_q;
  assign interior = (cur_row >= coord_t'(2)) && (cur_col >= coord_t'(2));

  // Row r-2 is refilled from row r-1, row r-1 from the incoming pixel.
  sobel_line_buf #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk_i  (clk_i),
    .we_i   (accept),
    .idx_i  (cur_col[AW-1:0]),
    .wdata_i(rd1),
    .rdata_o(rd0)
  );

  sobel_line_buf #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk_i  (clk_i),
    .we_i   (accept),
    .idx_i  (cur_col[AW-1:0]),
    .wdata_i(bus.pix_data_i),
    .rdata_o(rd1)
  );

  // Raster counters: column wraps at row end, both wrap at frame end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == COL_MAX) begin
        col_d = '0;
        row_d = (cur_row == ROW_MAX) ? '0 : cur_row + coord_t'(1);
      end else begin
        col_d = cur_col + coord_t'(1);
        row_d = cur_row;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Two-deep column history per window row; garbage near borders is never emitted.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      c1_q <= {bus.pix_data_i, rd1, rd0};
      c2_q <= c1_q;
    end
  end

  // Output register: load on interior accept, clear on border accept or consume.
  always_comb begin
    win_d  = win_q;
    wrow_d = wrow_q;
    wcol_d = wcol_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (accept) begin
      vld_d = interior;
      if (interior) begin
        win_d.p00 = c2_q[0];
        win_d.p02 = rd0;
        win_d.p10 = c2_q[1];
        win_d.p12 = rd1;
        win_d.p20 = c2_q[2];
        win_d.p22 = bus.pix_data_i;
        wrow_d    = cur_row - coord_t'(1);
        wcol_d    = cur_col - coord_t'(1);
        last_d    = (cur_row == ROW_MAX) && (cur_col == COL_MAX);
      end else begin
        last_d = 1'b0;
      end
    end else if (bus.win_ready_i) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q  <= '0;
      wrow_q <= '0;
      wcol_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      wrow_q <= wrow_d;
      wcol_q <= wcol_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign bus.win_valid_o = vld_q;
  assign bus.win_last_o  = last_q;
  assign bus.win_row_o   = wrow_q;
  assign bus.win_col_o   = wcol_q;
  assign bus.p00_o       = win_q.p00;
  assign bus.p02_o       = win_q.p02;
  assign bus.p10_o       = win_q.p10;
  assign bus.p12_o       = win_q.p12;
  assign bus.p20_o       = win_q.p20;
  assign bus.p22_o       = win_q.p22;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen: directed frames plus a random
// valid/ready/data phase, compared with an image-array reference model.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_window_gen_if u_if ();
  sobel_window_gen_if u_if3 ();

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (u_if.slave)
  );

  sobel_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) u_dut3 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (u_if3.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the current frame as a 2-D array, the raster position
  // of the next pixel, and the window that should currently be presented.
  int   img [H][W];
  int   pos;
  logic ev, elast;
  int   et [6];
  int   erow, ecol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] b8(input int v);
    return 32'(v & 255);
  endfunction

  function automatic logic [31:0] tap(input int k);
    case (k)
      0:       return {24'b0, u_if.p00_o};
      1:       return {24'b0, u_if.p02_o};
      2:       return {24'b0, u_if.p10_o};
      3:       return {24'b0, u_if.p12_o};
      4:       return {24'b0, u_if.p20_o};
      default: return {24'b0, u_if.p22_o};
    endcase
  endfunction

  task automatic check_out(input string tag);
    chk({tag, ".valid"}, {31'b0, u_if.win_valid_o}, {31'b0, ev});
    if (ev) begin
      for (int k = 0; k < 6; k++) chk($sformatf("%s.tap%0d", tag, k), tap(k), b8(et[k]));
      chk({tag, ".row"},  {16'b0, u_if.win_row_o}, 32'(erow));
      chk({tag, ".col"},  {16'b0, u_if.win_col_o}, 32'(ecol));
      chk({tag, ".last"}, {31'b0, u_if.win_last_o}, {31'b0, elast});
    end
  endtask

  task automatic check_taps(input string tag, input int t0, input int t1, input int t2,
                            input int t3, input int t4, input int t5);
    int t [6];
    t = '{t0, t1, t2, t3, t4, t5};
    for (int k = 0; k < 6; k++) chk($sformatf("%s.tap%0d", tag, k), tap(k), b8(t[k]));
  endtask

  // One clock: drive, check ready, clock, update model, check outputs.
  task automatic step(input logic v, input int d, input logic rdy, input logic sof,
                      output logic acc);
    int r, c;
    u_if.pix_valid_i = v;
    u_if.pix_data_i  = pixel_t'(d);
    u_if.win_ready_i = rdy;
`ifdef SOBEL_WIN_SOF_EN
    u_if.sof_i = sof;
`endif
    #1;
    chk("pix_ready", {31'b0, u_if.pix_ready_o}, {31'b0, (!ev || rdy)});
    acc = v && (!ev || rdy);
    @(posedge clk);
    #1;
    if (acc) begin
      if (sof) pos = 0;
      r = pos / W;
      c = pos % W;
      img[r][c] = d;
      if (r >= 2 && c >= 2) begin
        ev    = 1'b1;
        et[0] = img[r-2][c-2]; et[1] = img[r-2][c];
        et[2] = img[r-1][c-2]; et[3] = img[r-1][c];
        et[4] = img[r][c-2];   et[5] = img[r][c];
        erow  = r - 1;
        ecol  = c - 1;
        elast = (r == H - 1) && (c == W - 1);
      end else begin
        ev = 1'b0;
      end
      pos = (pos + 1) % (W * H);
    end else if (rdy) begin
      ev = 1'b0;
    end
    check_out("win");
  endtask

  task automatic send(input int d, input logic rdy, input logic sof);
    logic acc;
    int   guard = 0;
    do begin
      step(1'b1, d, rdy, sof, acc);
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    logic acc;
    step(1'b0, 0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   nwin, cur_d, got;

    u_if.pix_valid_i  = 1'b0;
    u_if.pix_data_i   = '0;
    u_if.win_ready_i  = 1'b0;
    u_if3.pix_valid_i = 1'b0;
    u_if3.pix_data_i  = '0;
    u_if3.win_ready_i = 1'b0;
`ifdef SOBEL_WIN_SOF_EN
    u_if.sof_i  = 1'b0;
    u_if3.sof_i = 1'b0;
`endif
    pos = 0; ev = 1'b0; elast = 1'b0; erow = 0; ecol = 0;
    for (int k = 0; k < 6; k++) et[k] = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'b0, u_if.win_valid_o}, 32'd0);
    chk("rst.last",  {31'b0, u_if.win_last_o},  32'd0);
    chk("rst.row",   {16'b0, u_if.win_row_o},   32'd0);
    chk("rst.col",   {16'b0, u_if.win_col_o},   32'd0);
    check_taps("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.ready", {31'b0, u_if.pix_ready_o}, 32'd1);
    chk("rst3.valid", {31'b0, u_if3.win_valid_o}, 32'd0);
    rst_n = 1'b1;

    // Basic frame, value 4r+c, always ready.
    nwin = 0;
    for (int i = 0; i < 16; i++) begin
      send(i, 1'b1, 1'b0);
      if (u_if.win_valid_o === 1'b1) nwin++;
      if (i == 10) begin
        check_taps("basic.first", 0, 2, 4, 6, 8, 10);
        chk("basic.first.row", {16'b0, u_if.win_row_o}, 32'd1);
        chk("basic.first.col", {16'b0, u_if.win_col_o}, 32'd1);
      end
      if (i == 15) begin
        check_taps("basic.last", 5, 7, 9, 11, 13, 15);
        chk("basic.last.row",  {16'b0, u_if.win_row_o},  32'd2);
        chk("basic.last.col",  {16'b0, u_if.win_col_o},  32'd2);
        chk("basic.last.last", {31'b0, u_if.win_last_o}, 32'd1);
      end
    end
    chk("basic.nwin", 32'(nwin), 32'd4);
    idle();

    // Backpressure: hold the first window for 5 cycles.
    for (int i = 0; i < 11; i++) send(i, 1'b1, 1'b0);
    repeat (5) begin
      step(1'b1, 11, 1'b0, 1'b0, acc);
      check_taps("bp.hold", 0, 2, 4, 6, 8, 10);
    end
    for (int i = 11; i < 16; i++) send(i, 1'b1, 1'b0);
    idle();

    // Back-to-back frames; second frame must not show first-frame data.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) begin
        send(f * 100 + i, 1'b1, 1'b0);
        if (f == 1 && i == 10) check_taps("b2b.first", 100, 102, 104, 106, 108, 110);
      end
    idle();

    // Signed extremes on the 3x3 instance.
    u_if3.pix_valid_i = 1'b1;
    u_if3.pix_data_i  = pixel_t'(-128);
    u_if3.win_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("s3.early_valid", {31'b0, u_if3.win_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    u_if3.pix_valid_i = 1'b0;
    chk("s3.valid", {31'b0, u_if3.win_valid_o}, 32'd1);
    chk("s3.p00", {24'b0, u_if3.p00_o}, 32'h80);
    chk("s3.p02", {24'b0, u_if3.p02_o}, 32'h80);
    chk("s3.p10", {24'b0, u_if3.p10_o}, 32'h80);
    chk("s3.p12", {24'b0, u_if3.p12_o}, 32'h80);
    chk("s3.p20", {24'b0, u_if3.p20_o}, 32'h80);
    chk("s3.p22", {24'b0, u_if3.p22_o}, 32'h80);
    chk("s3.row",  {16'b0, u_if3.win_row_o},  32'd1);
    chk("s3.col",  {16'b0, u_if3.win_col_o},  32'd1);
    chk("s3.last", {31'b0, u_if3.win_last_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("s3.drained", {31'b0, u_if3.win_valid_o}, 32'd0);

    // Reset while a window is pending: valid drops without a clock edge.
    for (int i = 0; i < 11; i++) send(i, 1'b1, 1'b0);
    step(1'b1, 11, 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async.valid", {31'b0, u_if.win_valid_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pos = 0; ev = 1'b0;

    // Reset after 6 pixels, then a fresh frame matches the basic frame.
    for (int i = 0; i < 6; i++) send(i, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.valid", {31'b0, u_if.win_valid_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pos = 0; ev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(i, 1'b1, 1'b0);
      if (i == 10) check_taps("rst_fresh.first", 0, 2, 4, 6, 8, 10);
      if (i == 15) check_taps("rst_fresh.last", 5, 7, 9, 11, 13, 15);
    end
    idle();

    // Random valid, ready and signed data over three frames.
    got   = 0;
    cur_d = int'($urandom_range(0, 255)) - 128;
    for (int cyc = 0; cyc < 2000 && got < 3 * W * H; cyc++) begin
      step($urandom_range(0, 3) != 0, cur_d, $urandom_range(0, 3) != 0, 1'b0, acc);
      if (acc) begin
        got++;
        cur_d = int'($urandom_range(0, 255)) - 128;
      end
    end
    chk("rand.pixels", 32'(got), 32'(3 * W * H));
    idle();

`ifdef SOBEL_WIN_SOF_EN
    // Start-of-frame on the 3rd pixel of row 2 restarts at (0,0).
    for (int i = 0; i < 10; i++) send(i, 1'b1, 1'b0);
    send(50, 1'b1, 1'b1);
    chk("sof.no_win", {31'b0, u_if.win_valid_o}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      send(50 + i, 1'b1, 1'b0);
      if (i == 9)  chk("sof.before", {31'b0, u_if.win_valid_o}, 32'd0);
      if (i == 10) begin
        chk("sof.win", {31'b0, u_if.win_valid_o}, 32'd1);
        chk("sof.p00", tap(0), 32'd50);
      end
    end
    for (int i = 11; i < 16; i++) send(50 + i, 1'b1, 1'b0);
    idle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
